// File: rtl/sysmem_arb_pkg.sv
// Shared types and constants for the system BRAM arbiter.
package sysmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Base of the peripheral window; the BRAM range check treats it as out of range.
  localparam logic [31:0] IO_BASE    = 32'h1000_0000;
  localparam logic [3:0]  WSTRB_READ = 4'b0000;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way grant logic: round-robin on ties, or fixed priority to requester 0.
module rr_arbiter_2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (FIXED_PRIO || last_grant_q) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[0]) last_grant_d = 1'b0;
    else if (gnt[1]) last_grant_d = 1'b1;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/sysmem_arbiter.sv
// Serialises two valid/ready masters onto the single-port byte-lane system BRAM.
// state | meaning
// IDLE  | arbitrate; winner drives the BRAM combinationally
// RESP  | ready (and err/rdata) to the registered winner
module sysmem_arbiter
  import sysmem_arb_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_valid,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_valid,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_rdata
);

  state_t        state_q, state_d;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          grant_ok;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          in_range;
  logic          addr_lsb_unused;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          gnt_q, err_q, rd_q;
  logic          resp;
  logic [31:0]   rdata_v;

  assign arb_en = (state_q == IDLE);

  rr_arbiter_2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({m1_valid, m0_valid}),
    .gnt   (gnt)
  );

  assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
  assign sel_wstrb = gnt[1] ? m1_wstrb : m0_wstrb;

  assign addr_lsb_unused = ^sel_addr[1:0];
  assign in_range = ((sel_addr >> (AW + 2)) == 32'd0);

  // A grant in the reset cycle is discarded so no write can slip through.
  assign grant_ok = arb_en && (gnt != 2'b00) && !reset;

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_we     = WSTRB_READ;
    if (grant_ok && in_range) begin
      ram_addr_d = sel_addr[AW+1:2];
      ram_we     = sel_wstrb;
    end
  end

  assign ram_addr  = ram_addr_d;
  assign ram_wdata = sel_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ok) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      if (grant_ok) begin
        gnt_q <= gnt[1];
        err_q <= !in_range;
        rd_q  <= (sel_wstrb == WSTRB_READ);
      end
    end
  end

  assign resp    = (state_q == RESP) && !reset;
  assign rdata_v = (rd_q && !err_q) ? ram_rdata : 32'h0;

  assign m0_ready = resp && !gnt_q;
  assign m1_ready = resp && gnt_q;
  assign m0_err   = m0_ready && err_q;
  assign m1_err   = m1_ready && err_q;
  assign m0_rdata = m0_ready ? rdata_v : 32'h0;
  assign m1_rdata = m1_ready ? rdata_v : 32'h0;

endmodule
